hit_stop_ctrl: RTL

//  Consumes the goose/bean collision flag from the hit detector and turns it into game response.
//  On a qualified hit it freezes gameplay for FREEZE_FRAMES frames and decrements lives.
//  It then grants INVULN_FRAMES frames of invulnerability.

---
 rtl/hit_stop_ctrl_pkg.sv | 24 ++
 rtl/hit_stop_ctrl_frame_timer.sv | 34 +++
 rtl/hit_stop_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/hit_stop_ctrl_pkg.sv
// Shared definitions for the hit-stop controller.
// State encodings are fixed so the score/VGA blocks can decode the game state
// directly from the 2-bit state value.
package hit_stop_ctrl_pkg;

    typedef enum logic [1:0] {
        HS_PLAY   = 2'd0,
        HS_FREEZE = 2'd1,
        HS_INVULN = 2'd2,
        HS_OVER   = 2'd3
    } hs_state_t;

    localparam int LIVES_DEFAULT = 3;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Counter width for a count running 0..n-1; at least one bit.
    function automatic int cnt_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hit_stop_ctrl_frame_timer.sv
// Frame tick counter shared by the FREEZE and INVULN phases.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   clr        : hold the count at zero (phase not timed)
//   tick       : one-clk frame pulse; advances the count
//   term       : terminal count (last frame index of the phase)
//   cnt        : current frame index within the phase
//   tc         : tick arriving at the terminal count; count returns to zero
module hit_stop_ctrl_frame_timer #(
    parameter int CW = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          tick,
    input  logic [CW-1:0] term,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    assign tc = tick & ~clr & (cnt == term);

    // Self-clears on terminal count, so it never wraps and the next phase
    // starts from zero without a separate clear.
    always_ff @(posedge clk) begin
        if (reset || clr)
            cnt <= '0;
        else if (tc)
            cnt <= '0;
        else if (tick)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/hit_stop_ctrl.sv
// Hit-stop controller: turns the level collision flag into freeze, life loss,
// invulnerability with sprite flash, and game over.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   frame_tick : one-clk pulse per video frame
//   hit        : level collision flag (may stay high for many cycles)
//   restart    : one-clk pulse, honoured only in OVER
//   game_en    : world advances (PLAY or INVULN)
//   freeze     : in FREEZE
//   invuln     : in INVULN
//   flash      : goose sprite blank, toggles during INVULN
//   lives      : remaining lives
//   game_over  : in OVER
module hit_stop_ctrl
    import hit_stop_ctrl_pkg::*;
#(
    parameter int FREEZE_FRAMES = 30,
    parameter int INVULN_FRAMES = 60,
    parameter int LIVES         = LIVES_DEFAULT,
    parameter int FLASH_DIV     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       hit,
    input  logic       restart,
    output logic       game_en,
    output logic       freeze,
    output logic       invuln,
    output logic       flash,
    output logic [2:0] lives,
    output logic       game_over
);

    localparam int CW = cnt_w(max2(FREEZE_FRAMES, INVULN_FRAMES));

    hs_state_t      state, state_nxt;
    logic [2:0]     lives_nxt;
    logic           flash_nxt;
    logic           hit_q;
    logic           qhit;
    logic           tmr_clr;
    logic           tmr_tc;
    logic           flash_pt;
    logic [CW-1:0]  tmr_term;
    logic [CW-1:0]  cnt;

    assign qhit = hit & ~hit_q;

    // One timer for both timed phases; only the terminal value changes.
    assign tmr_clr  = (state != HS_FREEZE) && (state != HS_INVULN);
    assign tmr_term = (state == HS_FREEZE) ? CW'(FREEZE_FRAMES - 1)
                                           : CW'(INVULN_FRAMES - 1);

    hit_stop_ctrl_frame_timer #(.CW(CW)) u_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (tmr_clr),
        .tick  (frame_tick),
        .term  (tmr_term),
        .cnt   (cnt),
        .tc    (tmr_tc)
    );

    assign flash_pt = frame_tick &&
                      ((int'(cnt) % FLASH_DIV) == (FLASH_DIV - 1));

    // hit_q keeps sampling during reset so a level held across reset is not
    // mistaken for a fresh edge on the first clock after release.
    always_ff @(posedge clk) begin
        hit_q <= hit;
        if (reset) begin
            state <= HS_PLAY;
            lives <= 3'(LIVES);
            flash <= 1'b0;
        end else begin
            state <= state_nxt;
            lives <= lives_nxt;
            flash <= flash_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        lives_nxt = lives;
        flash_nxt = flash;
        case (state)
            HS_PLAY: begin
                flash_nxt = 1'b0;
                // A same-cycle frame_tick is irrelevant: timer is held clear.
                if (qhit) begin
                    if (lives <= 3'd1) begin
                        lives_nxt = 3'd0;
                        state_nxt = HS_OVER;
                    end else begin
                        lives_nxt = lives - 3'd1;
                        state_nxt = HS_FREEZE;
                    end
                end
            end
            HS_FREEZE: begin
                if (tmr_tc)
                    state_nxt = HS_INVULN;
            end
            HS_INVULN: begin
                if (tmr_tc) begin
                    state_nxt = HS_PLAY;
                    flash_nxt = 1'b0;
                end else if (flash_pt) begin
                    flash_nxt = ~flash;
                end
            end
            HS_OVER: begin
                flash_nxt = 1'b0;
                if (restart) begin
                    lives_nxt = 3'(LIVES);
                    state_nxt = HS_PLAY;
                end
            end
            default: state_nxt = HS_PLAY;
        endcase
    end

    assign game_en   = (state == HS_PLAY) || (state == HS_INVULN);
    assign freeze    = (state == HS_FREEZE);
    assign invuln    = (state == HS_INVULN);
    assign game_over = (state == HS_OVER);

endmodule
